// File: rtl/hci_core_rr_arbiter_if.sv
// hci_core_rr_arbiter_if: HCI-Core request/response bundle.
// The master side issues requests and accepts responses (lrdy).
// The slave side grants requests and returns responses.
interface hci_core_rr_arbiter_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32,
  parameter int unsigned BW = 4,
  parameter int unsigned UW = 1
);
  // request channel
  logic          req;
  logic          gnt;
  logic [AW-1:0] add;
  logic          wen;
  logic [DW-1:0] data;
  logic [BW-1:0] be;
  logic [UW-1:0] user;
  // response channel
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_opc;
  logic [UW-1:0] r_user;
  logic          lrdy;

  modport master (
    output req, add, wen, data, be, user, lrdy,
    input  gnt, r_data, r_valid, r_opc, r_user
  );

  modport slave (
    input  req, add, wen, data, be, user, lrdy,
    output gnt, r_data, r_valid, r_opc, r_user
  );
endinterface

// File: rtl/hci_core_rr_arbiter.sv
// hci_core_rr_arbiter: shares one HCI-Core initiator port among NB_CHAN
// requesters. Round-robin arbitration; a request that is not granted at once
// stays locked on the initiator until it is granted. Each accepted
// transaction pushes its channel ID into an outstanding-ID FIFO so responses
// are steered back in order.
// Optional feature macro: HCI_CORE_ARB_PERF_EN adds per-channel grant
// counters and a multi-request conflict counter (saturating, 32 bit).
module hci_core_rr_arbiter #(
  parameter int unsigned NB_CHAN         = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned DW              = 32,
  parameter int unsigned AW              = 32,
  parameter int unsigned BW              = 4,
  parameter int unsigned UW              = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  hci_core_rr_arbiter_if.slave  tcdm_target [NB_CHAN],
  hci_core_rr_arbiter_if.master tcdm_initiator
`ifdef HCI_CORE_ARB_PERF_EN
  ,
  output logic [NB_CHAN-1:0][31:0] grant_cnt_o,
  output logic [31:0]              conflict_cnt_o
`endif
);

  localparam int unsigned ID_W  = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NB_CHAN - 1);
  localparam logic [ID_W:0]    NB_CHAN_W = (ID_W + 1)'(NB_CHAN);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // ---------------------------------------------------------------------
  // Flattened view of the requester ports (interface arrays can only be
  // indexed with constants, so everything goes through these vectors).
  // ---------------------------------------------------------------------
  logic [NB_CHAN-1:0] tgt_req;
  logic [NB_CHAN-1:0] tgt_wen;
  logic [NB_CHAN-1:0] tgt_lrdy;
  logic [NB_CHAN-1:0] tgt_gnt;
  logic [NB_CHAN-1:0] tgt_r_valid;
  logic [AW-1:0]      tgt_add  [NB_CHAN];
  logic [DW-1:0]      tgt_data [NB_CHAN];
  logic [BW-1:0]      tgt_be   [NB_CHAN];
  logic [UW-1:0]      tgt_user [NB_CHAN];

  // arbitration state
  state_e          state_q;
  logic [ID_W-1:0] rr_q;
  logic [ID_W-1:0] winner_q;

  // round-robin search
  logic [2*NB_CHAN-1:0] req_dbl;
  logic [NB_CHAN-1:0]   req_rot;
  logic                 rr_found;
  logic [ID_W-1:0]      rr_offset;
  logic [ID_W:0]        rr_sum;
  logic [ID_W:0]        rr_wrap;
  logic [ID_W-1:0]      rr_winner;

  // request path
  logic [ID_W-1:0] winner;
  logic            req_any;
  logic            init_req;
  logic            handshake;

  // outstanding-ID FIFO
  logic [ID_W-1:0]  fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ID_W-1:0]  head_id;
  logic             resp_valid;
  logic             fifo_push;
  logic             fifo_pop;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == LAST_ID) begin
      return '0;
    end
    return id + ID_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == LAST_PTR) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------
  // Per-channel port plumbing
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < int'(NB_CHAN); gi++) begin : g_chan
    assign tgt_req[gi]  = tcdm_target[gi].req;
    assign tgt_wen[gi]  = tcdm_target[gi].wen;
    assign tgt_lrdy[gi] = tcdm_target[gi].lrdy;
    assign tgt_add[gi]  = tcdm_target[gi].add;
    assign tgt_data[gi] = tcdm_target[gi].data;
    assign tgt_be[gi]   = tcdm_target[gi].be;
    assign tgt_user[gi] = tcdm_target[gi].user;

    // only the current winner can see a grant, and only on a real handshake
    assign tgt_gnt[gi]     = handshake && (winner == ID_W'(gi));
    // only the channel at the FIFO head sees the response strobe
    assign tgt_r_valid[gi] = resp_valid && (head_id == ID_W'(gi));

    assign tcdm_target[gi].gnt     = tgt_gnt[gi];
    assign tcdm_target[gi].r_valid = tgt_r_valid[gi];
    assign tcdm_target[gi].r_data  = tcdm_initiator.r_data;
    assign tcdm_target[gi].r_opc   = tcdm_initiator.r_opc;
    assign tcdm_target[gi].r_user  = tcdm_initiator.r_user;
  end

  // ---------------------------------------------------------------------
  // Round-robin winner: rotate the request vector so rr_q sits at bit 0,
  // find the lowest set bit, then rotate the offset back.
  // ---------------------------------------------------------------------
  assign req_dbl = {tgt_req, tgt_req} >> rr_q;
  assign req_rot = req_dbl[NB_CHAN-1:0];

  // Lowest set bit of the rotated request vector (descending loop, last hit wins).
  always_comb begin
    rr_found  = 1'b0;
    rr_offset = '0;
    for (int k = int'(NB_CHAN) - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        rr_found  = 1'b1;
        rr_offset = ID_W'(k);
      end
    end
  end

  assign rr_sum    = {1'b0, rr_q} + {1'b0, rr_offset};
  assign rr_wrap   = (rr_sum >= NB_CHAN_W) ? (rr_sum - NB_CHAN_W) : rr_sum;
  assign rr_winner = rr_wrap[ID_W-1:0];

  // A locked request keeps its slot so address and data stay stable.
  assign winner  = (state_q == ST_LOCKED) ? winner_q : rr_winner;
  assign req_any = (state_q == ST_LOCKED) ? tgt_req[winner_q] : rr_found;

  // A full FIFO blocks new requests; so do reset and clear, so that no ID
  // is accepted in a cycle whose FIFO contents are about to be discarded.
  assign init_req  = req_any && !fifo_full && !clear_i && !rst_i;
  assign handshake = init_req && tcdm_initiator.gnt;

  assign tcdm_initiator.req  = init_req;
  assign tcdm_initiator.add  = tgt_add[winner];
  assign tcdm_initiator.wen  = tgt_wen[winner];
  assign tcdm_initiator.data = tgt_data[winner];
  assign tcdm_initiator.be   = tgt_be[winner];
  assign tcdm_initiator.user = tgt_user[winner];

  // ---------------------------------------------------------------------
  // Response path, steered by the oldest outstanding ID
  // ---------------------------------------------------------------------
  assign fifo_full  = (fifo_cnt_q == FULL_CNT);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign head_id    = fifo_mem[rd_ptr_q];

  // A response with nothing outstanding has no owner and is dropped.
  assign resp_valid          = tcdm_initiator.r_valid && !fifo_empty;
  assign tcdm_initiator.lrdy = fifo_empty ? 1'b1 : tgt_lrdy[head_id];

  assign fifo_push = handshake;
  assign fifo_pop  = resp_valid && tcdm_initiator.lrdy;

  // Arbitration FSM: IDLE searches round-robin, LOCKED pins an ungranted winner.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rr_q     <= '0;
      winner_q <= '0;
    end else if (clear_i) begin
      state_q  <= ST_IDLE;
      rr_q     <= '0;
      winner_q <= '0;
    end else if (!fifo_full) begin
      unique case (state_q)
        ST_IDLE: begin
          if (handshake) begin
            rr_q <= next_id(rr_winner);
          end else if (rr_found) begin
            state_q  <= ST_LOCKED;
            winner_q <= rr_winner;
          end
        end
        ST_LOCKED: begin
          if (!tgt_req[winner_q]) begin
            // requester withdrew a pending request: abandon it, nothing pushed
            state_q <= ST_IDLE;
          end else if (handshake) begin
            state_q <= ST_IDLE;
            rr_q    <= next_id(winner_q);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outstanding-ID storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_q] <= winner;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (clear_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (fifo_pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      unique case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

`ifdef HCI_CORE_ARB_PERF_EN
  // ---------------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------------
  logic multi_req;
  assign multi_req = |(tgt_req & (tgt_req - NB_CHAN'(1)));

  for (genvar gi = 0; gi < int'(NB_CHAN); gi++) begin : g_perf
    // Count accepted requests of this channel.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        grant_cnt_o[gi] <= '0;
      end else if (clear_i) begin
        grant_cnt_o[gi] <= '0;
      end else if (tgt_gnt[gi] && (grant_cnt_o[gi] != '1)) begin
        grant_cnt_o[gi] <= grant_cnt_o[gi] + 32'd1;
      end
    end
  end

  // Count cycles in which two or more requesters compete.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conflict_cnt_o <= '0;
    end else if (clear_i) begin
      conflict_cnt_o <= '0;
    end else if (multi_req && (conflict_cnt_o != '1)) begin
      conflict_cnt_o <= conflict_cnt_o + 32'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Protocol checks on the neighbours
  // ---------------------------------------------------------------------
  a_locked_req_held : assert property (
    @(posedge clk_i) disable iff (rst_i || clear_i)
    (state_q == ST_LOCKED) |-> tgt_req[winner_q]
  );

  a_no_orphan_resp : assert property (
    @(posedge clk_i) disable iff (rst_i || clear_i)
    tcdm_initiator.r_valid |-> !fifo_empty
  );

endmodule

// File: tb/tb_hci_core_rr_arbiter.sv
// tb_hci_core_rr_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based behavioural model.
module tb_hci_core_rr_arbiter;
  localparam int NB_CHAN = 4;
  localparam int MAX_OUT = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = 4;
  localparam int UW = 1;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  always #5 clk = ~clk;

  hci_core_rr_arbiter_if #(.DW(DW), .AW(AW), .BW(BW), .UW(UW)) tgt_if [NB_CHAN] ();
  hci_core_rr_arbiter_if #(.DW(DW), .AW(AW), .BW(BW), .UW(UW)) init_if ();

  // stimulus
  logic [NB_CHAN-1:0] d_req;
  logic [NB_CHAN-1:0] d_lrdy;
  logic [NB_CHAN-1:0] d_wen;
  logic [AW-1:0]      d_add  [NB_CHAN];
  logic [DW-1:0]      d_data [NB_CHAN];
  logic               i_gnt;
  logic               i_rvalid;
  logic [DW-1:0]      i_rdata;
  // observation
  logic [NB_CHAN-1:0] o_gnt;
  logic [NB_CHAN-1:0] o_rvalid;
  logic [DW-1:0]      o_rdata [NB_CHAN];

`ifdef HCI_CORE_ARB_PERF_EN
  logic [NB_CHAN-1:0][31:0] grant_cnt;
  logic [31:0]              conflict_cnt;
`endif

  for (genvar gi = 0; gi < NB_CHAN; gi++) begin : g_tgt
    assign tgt_if[gi].req  = d_req[gi];
    assign tgt_if[gi].add  = d_add[gi];
    assign tgt_if[gi].wen  = d_wen[gi];
    assign tgt_if[gi].data = d_data[gi];
    assign tgt_if[gi].be   = '1;
    assign tgt_if[gi].user = '0;
    assign tgt_if[gi].lrdy = d_lrdy[gi];
    assign o_gnt[gi]       = tgt_if[gi].gnt;
    assign o_rvalid[gi]    = tgt_if[gi].r_valid;
    assign o_rdata[gi]     = tgt_if[gi].r_data;
  end

  assign init_if.gnt     = i_gnt;
  assign init_if.r_valid = i_rvalid;
  assign init_if.r_data  = i_rdata;
  assign init_if.r_opc   = 1'b0;
  assign init_if.r_user  = '0;

  hci_core_rr_arbiter #(
    .NB_CHAN(NB_CHAN), .MAX_OUTSTANDING(MAX_OUT),
    .DW(DW), .AW(AW), .BW(BW), .UW(UW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clear_i        (clear),
    .tcdm_target    (tgt_if),
    .tcdm_initiator (init_if)
`ifdef HCI_CORE_ARB_PERF_EN
    ,
    .grant_cnt_o    (grant_cnt),
    .conflict_cnt_o (conflict_cnt)
`endif
  );

  // ---------------- behavioural model ----------------
  int m_rr;        // channel that has priority next
  int m_lock;      // channel holding an ungranted request, -1 if none
  int m_q[$];      // IDs of accepted, unanswered transactions (oldest first)
  // expectations of the current cycle, consumed by tick()
  int cur_cand;
  int cur_head;
  bit cur_hs;
  bit cur_full;
  bit cur_lrdy;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr   = 0;
    m_lock = -1;
    m_q.delete();
  endtask

  // Compare the combinational outputs mid-cycle (inputs were driven #1 after the edge).
  task automatic eval();
    logic [NB_CHAN-1:0] e_gnt;
    logic [NB_CHAN-1:0] e_rv;
    bit e_req;
    int ridx;
    #4;
    if (rst) model_reset();
    cur_full = (m_q.size() == MAX_OUT);
    cur_cand = -1;
    if (m_lock >= 0) begin
      if (d_req[m_lock]) cur_cand = m_lock;
    end else begin
      for (int k = 0; k < NB_CHAN; k++) begin
        int c;
        c = (m_rr + k) % NB_CHAN;
        if (cur_cand < 0 && d_req[c]) cur_cand = c;
      end
    end
    e_req    = (cur_cand >= 0) && !cur_full && !clear && !rst;
    cur_hs   = e_req && i_gnt;
    e_gnt    = cur_hs ? NB_CHAN'(1 << cur_cand) : '0;
    cur_head = (m_q.size() > 0) ? m_q[0] : -1;
    e_rv     = (cur_head >= 0 && i_rvalid) ? NB_CHAN'(1 << cur_head) : '0;
    cur_lrdy = (cur_head < 0) ? 1'b1 : d_lrdy[cur_head];

    check("init_req", 32'(init_if.req), 32'(e_req));
    check("tgt_gnt", 32'(o_gnt), 32'(e_gnt));
    if (e_req) begin
      check("init_add", init_if.add, d_add[cur_cand]);
      check("init_data", init_if.data, d_data[cur_cand]);
      check("init_wen", 32'(init_if.wen), 32'(d_wen[cur_cand]));
    end
    check("tgt_rvalid", 32'(o_rvalid), 32'(e_rv));
    check("init_lrdy", 32'(init_if.lrdy), 32'(cur_lrdy));
    ridx = int'($urandom_range(NB_CHAN - 1, 0));
    check("r_data_bcast", o_rdata[ridx], i_rdata);
  endtask

  // Advance one clock and apply the cycle's effects to the model.
  task automatic tick();
    @(posedge clk);
    if (rst || clear) begin
      model_reset();
    end else begin
      if (cur_head >= 0 && i_rvalid && cur_lrdy) void'(m_q.pop_front());
      if (!cur_full) begin
        if (cur_hs) begin
          m_q.push_back(cur_cand);
          m_rr   = (cur_cand + 1) % NB_CHAN;
          m_lock = -1;
        end else if (m_lock >= 0) begin
          if (!d_req[m_lock]) m_lock = -1;
        end else if (cur_cand >= 0) begin
          m_lock = cur_cand;
        end
      end
    end
    #1;
  endtask

  task automatic step();
    eval();
    tick();
  endtask

  initial begin
    rst      = 1'b1;
    clear    = 1'b0;
    d_req    = '1;
    d_lrdy   = '1;
    d_wen    = '0;
    i_gnt    = 1'b1;
    i_rvalid = 1'b0;
    i_rdata  = 32'hCAFE_0000;
    for (int c = 0; c < NB_CHAN; c++) begin
      d_add[c]  = 32'h1000 * (c + 1);
      d_data[c] = 32'hD000_0000 + c;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // reset state: requests present but nothing granted while in reset
    eval();
    check("rst_gnt", 32'(o_gnt), 32'h0);
    check("rst_rvalid", 32'(o_rvalid), 32'h0);
    check("rst_init_req", 32'(init_if.req), 32'h0);
    tick();
    rst   = 1'b0;
    d_req = '0;
    eval();
    check("idle_init_req", 32'(init_if.req), 32'h0);
    tick();

    // fairness: all request, grant every cycle, response one cycle later
    d_req = '1;
    i_gnt = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i_rvalid = (k > 0);
      i_rdata  = $urandom;
      eval();
      check("fair_gnt", 32'(o_gnt), 32'(1 << (k % 4)));
      check("fair_rvalid", 32'(o_rvalid), (k > 0) ? 32'(1 << ((k - 1) % 4)) : 32'h0);
      tick();
    end
    d_req    = '0;
    i_rvalid = 1'b1;
    step();
    i_rvalid = 1'b0;

    // lock: ch1 (0x100) and ch2 pending, initiator withholds grant
    d_add[1] = 32'h100;
    d_add[2] = 32'h200;
    d_req    = 4'b0110;
    i_gnt    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      eval();
      check("lock_add", init_if.add, 32'h100);
      check("lock_nognt", 32'(o_gnt), 32'h0);
      tick();
      d_add[2] = 32'h200 + 32'(k + 1);
    end
    i_gnt = 1'b1;
    eval();
    check("lock_gnt1", 32'(o_gnt), 32'h2);
    tick();
    eval();
    check("lock_gnt2", 32'(o_gnt), 32'h4);
    check("lock_add2", init_if.add, d_add[2]);
    tick();
    d_req    = '0;
    i_gnt    = 1'b0;
    i_rvalid = 1'b1;
    eval();
    check("lock_resp1", 32'(o_rvalid), 32'h2);
    tick();
    eval();
    check("lock_resp2", 32'(o_rvalid), 32'h4);
    tick();
    i_rvalid = 1'b0;

    // backpressure: head ID 3 with its lrdy low for two cycles
    d_req = 4'b1000;
    i_gnt = 1'b1;
    step();
    d_req    = '0;
    i_rvalid = 1'b1;
    d_lrdy   = 4'b0111;
    for (int k = 0; k < 2; k++) begin
      eval();
      check("bp_lrdy", 32'(init_if.lrdy), 32'h0);
      check("bp_rvalid", 32'(o_rvalid), 32'h8);
      tick();
    end
    d_lrdy = '1;
    eval();
    check("bp_lrdy_rise", 32'(init_if.lrdy), 32'h1);
    check("bp_rvalid_rise", 32'(o_rvalid), 32'h8);
    tick();
    i_rvalid = 1'b0;
    step();

    // full: no responses, continuous requests
    d_req = '1;
    i_gnt = 1'b1;
    for (int k = 0; k < MAX_OUT + 2; k++) begin
      eval();
      check("full_req", 32'(init_if.req), (k < MAX_OUT) ? 32'h1 : 32'h0);
      tick();
    end
    i_rvalid = 1'b1;
    eval();
    check("full_pop_same_cycle", 32'(init_if.req), 32'h0);
    check("full_pop_nognt", 32'(o_gnt), 32'h0);
    tick();
    i_rvalid = 1'b0;
    eval();
    check("full_regrant", 32'(|o_gnt), 32'h1);
    tick();
    d_req    = '0;
    i_rvalid = 1'b1;
    repeat (MAX_OUT) step();
    i_rvalid = 1'b0;

    // reset while LOCKED with two IDs outstanding
    d_req = 4'b0001;
    i_gnt = 1'b1;
    step();
    step();
    d_req = 4'b0010;
    i_gnt = 1'b0;
    step();
    eval();
    check("pre_rst_locked_gnt", 32'(o_gnt), 32'h0);
    tick();
    rst      = 1'b1;
    i_rvalid = 1'b1;
    i_gnt    = 1'b1;
    eval();
    check("midrst_gnt", 32'(o_gnt), 32'h0);
    check("midrst_rvalid", 32'(o_rvalid), 32'h0);
    check("midrst_lrdy", 32'(init_if.lrdy), 32'h1);
    tick();
    rst      = 1'b0;
    i_rvalid = 1'b0;
    d_req    = 4'b0100;
    eval();
    check("postrst_gnt_ch2", 32'(o_gnt), 32'h4);
    tick();
    d_req    = '0;
    i_rvalid = 1'b1;
    step();
    i_rvalid = 1'b0;

`ifdef HCI_CORE_ARB_PERF_EN
    // performance counters: ch0+ch1 for 10 cycles with gnt=1
    clear = 1'b1;
    step();
    clear = 1'b0;
    d_req = 4'b0011;
    i_gnt = 1'b1;
    for (int k = 0; k < 10; k++) begin
      i_rvalid = (k > 0);
      step();
    end
    d_req    = '0;
    i_rvalid = 1'b1;
    eval();
    check("perf_gnt0", grant_cnt[0], 32'd5);
    check("perf_gnt1", grant_cnt[1], 32'd5);
    check("perf_gnt2", grant_cnt[2], 32'd0);
    check("perf_gnt3", grant_cnt[3], 32'd0);
    check("perf_conflict", conflict_cnt, 32'd10);
    tick();
    i_rvalid = 1'b0;
`endif

    // randomized traffic against the model (requesters honour the lock rule)
    for (int n = 0; n < 400; n++) begin
      d_req = NB_CHAN'($urandom);
      for (int c = 0; c < NB_CHAN; c++) begin
        if (c != m_lock) begin
          d_add[c]  = $urandom;
          d_data[c] = $urandom;
          d_wen[c]  = 1'($urandom);
        end
      end
      if (m_lock >= 0) d_req[m_lock] = 1'b1;
      d_lrdy   = NB_CHAN'($urandom);
      i_gnt    = ($urandom_range(3, 0) != 0);
      i_rvalid = (m_q.size() > 0) && ($urandom_range(1, 0) == 1);
      i_rdata  = $urandom;
      clear    = ($urandom_range(49, 0) == 0);
      step();
    end
    clear = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
